cp0_exc: RTL

- Coprocessor-0 exception/interrupt controller for the multicycle MIPS core.
- Latches hardware interrupt lines and holds the SR/Cause/EPC/PrId registers.
- Raises an interrupt request to the controller.
- Supplies the return address (epc) that the fetch unit loads on eret.
- Services mtc0/mfc0 from the datapath; exception entry/exit is driven by controller strobes.

---
 rtl/cp0_exc.sv | 98 +++++++++
 1 files changed

// File: rtl/cp0_exc.sv
// Coprocessor-0 exception/interrupt controller for the multicycle MIPS core.
// Holds SR (IM/EXL/IE), Cause (IP), EPC and PrId, raises intreq toward the
// controller, and serves mtc0/mfc0 accesses from the datapath.
module cp0_exc #(
   parameter logic [31:0] PRID     = 32'h0000_4D31,
   parameter logic [5:0]  IM_RESET = 6'b000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   input  logic        we,
   input  logic [31:0] pc_ret,
   input  logic [5:0]  hwint,
   input  logic        exl_set,
   input  logic        exl_clr,
   output logic [31:0] dout,
   output logic [31:0] epc,
   output logic        intreq
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic [5:0]  ip_q, ip_d;
   logic [31:0] epc_q, epc_d;

   // Next-state: updates applied from lowest to highest priority so the
   // strongest source is the last assignment (we < exl_clr < exl_set).
   always_comb begin
      // NOTE: every target gets a default first; a path that leaves one
      // unassigned would infer a latch.
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      epc_d = epc_q;
      ip_d  = hwint;            // one register stage, no hwint->intreq path

      if (we && addr == ADDR_SR) begin
         im_d  = din[15:10];
         exl_d = din[1];
         ie_d  = din[0];
      end
      if (we && addr == ADDR_EPC) begin
         epc_d = {din[31:2], 2'b00};
      end
      if (exl_clr) begin
         exl_d = 1'b0;
      end
      if (exl_set) begin
         // Nested entry beats eret; IM/IE from a concurrent SR write survive.
         exl_d = 1'b1;
         epc_d = {pc_ret[31:2], 2'b00};
      end
   end

   // State register with synchronous reset overriding every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from the same pre-edge values.
      if (rst) begin
         // NOTE: every register here is architecturally visible, so all of
         // them are reset; there is no storage array left uninitialised.
         im_q  <= IM_RESET;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         ip_q  <= 6'b000000;
         epc_q <= 32'h0000_0000;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         ip_q  <= ip_d;
         epc_q <= epc_d;
      end
   end

   // mfc0 read mux; reflects pre-edge state, so a same-cycle write reads old.
   always_comb begin
      dout = 32'h0000_0000;
      case (addr)
         ADDR_SR:    dout = {16'b0, im_q, 8'b0, exl_q, ie_q};
         ADDR_CAUSE: dout = {16'b0, ip_q, 10'b0};
         ADDR_EPC:   dout = epc_q;
         ADDR_PRID:  dout = PRID;
         default:    dout = 32'h0000_0000;
      endcase
   end

   assign epc    = epc_q;
   assign intreq = (|(ip_q & im_q)) & ie_q & ~exl_q;

endmodule
